// File: rtl/k12a_sequencer.sv
// K12A sequencer: state register, instruction register, skip flag, wake
// synchroniser/edge detector, single-step redirect and retired-instruction counter.

package k12a_pkg;

  typedef enum logic [2:0] {
    STATE_FETCH1 = 3'd0,
    STATE_FETCH2 = 3'd1,
    STATE_FETCH3 = 3'd2,
    STATE_EXEC   = 3'd3,
    STATE_POP    = 3'd4,
    STATE_RJMP   = 3'd5,
    STATE_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SKIP_SEL_HOLD               = 2'd0,
    SKIP_SEL_0                  = 2'd1,
    SKIP_SEL_CONDITION          = 2'd2,
    SKIP_SEL_CONDITION_INVERTED = 2'd3
  } skip_sel_t;

endpackage

module k12a_sequencer
  import k12a_pkg::*;
#(
  parameter int WAKE_SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  state_t      next_state,
  input  logic        inst_high_store,
  input  logic        inst_low_store,
  input  skip_sel_t   skip_sel,
  input  logic        alu_condition,
  input  logic [7:0]  data_bus,
  input  logic        wake_async,
  input  logic        step_mode,
  output state_t      state,
  output logic [15:0] inst,
  output logic        skip,
  output logic        wake,
  output logic        halted,
  output logic [15:0] retired_count
);

  state_t                      state_q, state_d;
  logic [15:0]                 inst_q, inst_d;
  logic                        skip_q, skip_d;
  logic [15:0]                 retired_q, retired_d;
  logic [WAKE_SYNC_STAGES-1:0] sync_q;
  logic                        wake_prev_q;

  logic in_retire_state;
  logic step_redirect;
  logic retire;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_retire_state = (state_q == STATE_EXEC) || (state_q == STATE_POP) ||
                      (state_q == STATE_RJMP);
    step_redirect   = step_mode && (next_state == STATE_FETCH1) && in_retire_state;
    state_d         = step_redirect ? STATE_HALT : next_state;

    // EXEC->POP/RJMP is not a retirement; the instruction retires on leaving POP/RJMP.
    retire    = in_retire_state &&
                ((state_d == STATE_FETCH1) || (state_d == STATE_HALT));
    retired_d = retire ? retired_q + 16'd1 : retired_q;

    inst_d = inst_q;
    if (inst_high_store) inst_d[15:8] = data_bus;
    if (inst_low_store)  inst_d[7:0]  = data_bus;

    skip_d = skip_q;
    unique case (skip_sel)
      SKIP_SEL_HOLD:               skip_d = skip_q;
      SKIP_SEL_0:                  skip_d = 1'b0;
      SKIP_SEL_CONDITION:          skip_d = alu_condition;
      SKIP_SEL_CONDITION_INVERTED: skip_d = ~alu_condition;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_FETCH1;
      inst_q      <= 16'h0000;
      skip_q      <= 1'b0;
      retired_q   <= 16'h0000;
      sync_q      <= '0;
      wake_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      skip_q      <= skip_d;
      retired_q   <= retired_d;
      sync_q      <= {sync_q[WAKE_SYNC_STAGES-2:0], wake_async};
      wake_prev_q <= sync_q[WAKE_SYNC_STAGES-1];
    end
  end

  assign state         = state_q;
  assign inst          = inst_q;
  assign skip          = skip_q;
  assign retired_count = retired_q;
  assign halted        = (state_q == STATE_HALT);
  assign wake          = sync_q[WAKE_SYNC_STAGES-1] & ~wake_prev_q;

endmodule

// File: tb/tb_k12a_sequencer.sv
// Scenario bench for k12a_sequencer: expected outputs are queued as stimulus is
// driven and popped/compared one cycle later, after the clock edge.

module tb_k12a_sequencer;
  import k12a_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  state_t      next_state;
  logic        inst_high_store;
  logic        inst_low_store;
  skip_sel_t   skip_sel;
  logic        alu_condition;
  logic [7:0]  data_bus;
  logic        wake_async;
  logic        step_mode;
  state_t      state;
  logic [15:0] inst;
  logic        skip;
  logic        wake;
  logic        halted;
  logic [15:0] retired_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    state_t      st;
    logic [15:0] inst;
    logic        skip;
    logic        halted;
    logic        wake;
    logic [15:0] ret;
  } exp_t;

  typedef struct packed {
    state_t     ns;
    logic       hs;
    logic       ls;
    skip_sel_t  ss;
    logic       cond;
    logic [7:0] db;
  } stim_t;

  exp_t exp_q[$];

  k12a_sequencer #(.WAKE_SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .next_state     (next_state),
    .inst_high_store(inst_high_store),
    .inst_low_store (inst_low_store),
    .skip_sel       (skip_sel),
    .alu_condition  (alu_condition),
    .data_bus       (data_bus),
    .wake_async     (wake_async),
    .step_mode      (step_mode),
    .state          (state),
    .inst           (inst),
    .skip           (skip),
    .wake           (wake),
    .halted         (halted),
    .retired_count  (retired_count)
  );

  always #5 clock = ~clock;

  function automatic stim_t mk_s(input state_t ns, input logic hs, input logic ls,
                                 input skip_sel_t ss, input logic cond, input logic [7:0] db);
    stim_t s;
    s.ns = ns; s.hs = hs; s.ls = ls; s.ss = ss; s.cond = cond; s.db = db;
    return s;
  endfunction

  function automatic stim_t go(input state_t ns);
    return mk_s(ns, 1'b0, 1'b0, SKIP_SEL_HOLD, 1'b0, 8'h00);
  endfunction

  function automatic exp_t mk_e(input state_t st, input logic [15:0] i, input logic sk,
                                input logic [15:0] r);
    exp_t e;
    e.st = st; e.inst = i; e.skip = sk; e.halted = (st == STATE_HALT);
    e.wake = 1'b0; e.ret = r;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.st = state; o.inst = inst; o.skip = skip; o.halted = halted;
    o.wake = wake; o.ret = retired_count;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    next_state      = s.ns;
    inst_high_store = s.hs;
    inst_low_store  = s.ls;
    skip_sel        = s.ss;
    alu_condition   = s.cond;
    data_bus        = s.db;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t got, want;
    reset_n = 1'b0;
    wake_async = 1'b0;
    step_mode  = 1'b0;
    drive(go(STATE_FETCH1));
    #3;
    exp_q.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b0, 16'h0000));
    got = observed(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL reset_state got=%h want=%h", got, want);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(STATE_FETCH2, 1'b1, 1'b0, SKIP_SEL_HOLD, 1'b0, 8'hA5));
    e.push_back(mk_e(STATE_FETCH2, 16'hA500, 1'b0, 16'd0));
    s.push_back(mk_s(STATE_FETCH3, 1'b0, 1'b1, SKIP_SEL_HOLD, 1'b0, 8'h3C));
    e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b0, 16'd0));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b0, 16'd0));
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_FETCH1, 16'hA53C, 1'b0, 16'd1));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL fetch[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_skip();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(go(STATE_FETCH2)); e.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b0, 16'd1));
    s.push_back(go(STATE_FETCH3)); e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b0, 16'd1));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b0, 16'd1));
    s.push_back(mk_s(STATE_FETCH1, 1'b0, 1'b0, SKIP_SEL_CONDITION, 1'b1, 8'h00));
    e.push_back(mk_e(STATE_FETCH1, 16'hA53C, 1'b1, 16'd2));
    s.push_back(mk_s(STATE_FETCH2, 1'b0, 1'b0, SKIP_SEL_0, 1'b1, 8'h00));
    e.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b0, 16'd2));
    s.push_back(mk_s(STATE_FETCH3, 1'b0, 1'b0, SKIP_SEL_CONDITION_INVERTED, 1'b1, 8'h00));
    e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b0, 16'd2));
    s.push_back(mk_s(STATE_EXEC, 1'b0, 1'b0, SKIP_SEL_CONDITION_INVERTED, 1'b0, 8'h00));
    e.push_back(mk_e(STATE_EXEC, 16'hA53C, 1'b1, 16'd2));
    s.push_back(mk_s(STATE_FETCH1, 1'b0, 1'b0, SKIP_SEL_CONDITION, 1'b0, 8'h00));
    e.push_back(mk_e(STATE_FETCH1, 16'hA53C, 1'b0, 16'd3));
    s.push_back(mk_s(STATE_FETCH2, 1'b0, 1'b0, SKIP_SEL_CONDITION, 1'b1, 8'h00));
    e.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b1, 16'd3));
    s.push_back(mk_s(STATE_FETCH3, 1'b0, 1'b0, SKIP_SEL_HOLD, 1'b0, 8'h00));
    e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b1, 16'd3));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b1, 16'd3));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL skip[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Decoder stand-in: stays in HALT until wake, then returns FETCH1.
  task automatic wake_from_halt(input string nm, input logic [15:0] ei, input logic es,
                                input logic [15:0] er);
    exp_t got, want, e;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(go(((state == STATE_HALT) && !wake) ? STATE_HALT : STATE_FETCH1));
      wake_async = (i < 5);
      e = mk_e((i < 2) ? STATE_HALT : STATE_FETCH1, ei, es, er);
      e.wake = (i == 1);
      exp_q.push_back(e);
      tick();
      if (wake) pulses++;
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL %s_wake[%0d] got=%h want=%h", nm, i, got, want);
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL %s_wake_pulses got=%0d want=1", nm, pulses);
    end
  endtask

  task automatic test_halt();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(go(STATE_HALT)); e.push_back(mk_e(STATE_HALT, 16'hA53C, 1'b1, 16'd4));
    s.push_back(go(STATE_HALT)); e.push_back(mk_e(STATE_HALT, 16'hA53C, 1'b1, 16'd4));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL halt[%0d] got=%h want=%h", i, got, want);
      end
    end
    wake_from_halt("halt", 16'hA53C, 1'b1, 16'd4);
  endtask

  task automatic test_step();
    stim_t s[$]; exp_t e[$]; stim_t s2[$]; exp_t e2[$]; exp_t got, want;
    step_mode = 1'b1;
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_FETCH1, 16'hA53C, 1'b1, 16'd4));
    s.push_back(go(STATE_FETCH2)); e.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b1, 16'd4));
    s.push_back(go(STATE_FETCH3)); e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b1, 16'd4));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b1, 16'd4));
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_HALT,   16'hA53C, 1'b1, 16'd5));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL step_exec[%0d] got=%h want=%h", i, got, want);
      end
    end
    wake_from_halt("step_exec", 16'hA53C, 1'b1, 16'd5);
    s2.push_back(go(STATE_FETCH2)); e2.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b1, 16'd5));
    s2.push_back(go(STATE_FETCH3)); e2.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b1, 16'd5));
    s2.push_back(go(STATE_EXEC));   e2.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b1, 16'd5));
    s2.push_back(go(STATE_RJMP));   e2.push_back(mk_e(STATE_RJMP,   16'hA53C, 1'b1, 16'd5));
    s2.push_back(go(STATE_FETCH1)); e2.push_back(mk_e(STATE_HALT,   16'hA53C, 1'b1, 16'd6));
    foreach (s2[i]) begin
      drive(s2[i]); exp_q.push_back(e2[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL step_rjmp[%0d] got=%h want=%h", i, got, want);
      end
    end
    wake_from_halt("step_rjmp", 16'hA53C, 1'b1, 16'd6);
    step_mode = 1'b0;
  endtask

  task automatic test_pop();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(go(STATE_FETCH2)); e.push_back(mk_e(STATE_FETCH2, 16'hA53C, 1'b1, 16'd6));
    s.push_back(go(STATE_FETCH3)); e.push_back(mk_e(STATE_FETCH3, 16'hA53C, 1'b1, 16'd6));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'hA53C, 1'b1, 16'd6));
    s.push_back(go(STATE_POP));    e.push_back(mk_e(STATE_POP,    16'hA53C, 1'b1, 16'd6));
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_FETCH1, 16'hA53C, 1'b1, 16'd7));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL pop[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$]; exp_t e[$]; stim_t s2[$]; exp_t e2[$]; exp_t got, want;
    s.push_back(mk_s(STATE_FETCH1, 1'b1, 1'b1, SKIP_SEL_HOLD, 1'b0, 8'h00));
    e.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b1, 16'd7));
    s.push_back(mk_s(STATE_FETCH2, 1'b1, 1'b0, SKIP_SEL_HOLD, 1'b0, 8'h12));
    e.push_back(mk_e(STATE_FETCH2, 16'h1200, 1'b1, 16'd7));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset_mid_pre[%0d] got=%h want=%h", i, got, want);
      end
    end
    #1;
    reset_n = 1'b0;
    exp_q.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b0, 16'h0000));
    #1;
    got = observed(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL reset_async got=%h want=%h", got, want);
    end
    @(negedge clock);
    reset_n = 1'b1;
    s2.push_back(go(STATE_FETCH2)); e2.push_back(mk_e(STATE_FETCH2, 16'h0000, 1'b0, 16'd0));
    s2.push_back(go(STATE_FETCH1)); e2.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b0, 16'd0));
    foreach (s2[i]) begin
      drive(s2[i]); exp_q.push_back(e2[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset_resume[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'h0000, 1'b0, 16'hFFFE));
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b0, 16'hFFFF));
    s.push_back(go(STATE_EXEC));   e.push_back(mk_e(STATE_EXEC,   16'h0000, 1'b0, 16'hFFFF));
    s.push_back(go(STATE_FETCH1)); e.push_back(mk_e(STATE_FETCH1, 16'h0000, 1'b0, 16'h0000));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(e[i]); tick();
      got = observed(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL wrap[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_skip();
    test_halt();
    test_step();
    test_pop();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
